// File: rtl/fft_pkg.sv
// Shared constants, state encoding and index helpers for the 16-point FFT
// controller and the butterfly stage blocks that sit beside it.
package fft_pkg;

  localparam int N     = 16;
  localparam int LOG2N = 4;
  localparam int DW    = 16;
  localparam int CW    = 32;

  // Twiddles W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), packed {real, imag} in Q8.8.
  localparam logic [CW-1:0] W0 = {16'h0100, 16'h0000};
  localparam logic [CW-1:0] W1 = {16'h00ED, 16'hFF9E};
  localparam logic [CW-1:0] W2 = {16'h00B5, 16'hFF4B};
  localparam logic [CW-1:0] W3 = {16'h0062, 16'hFF13};
  localparam logic [CW-1:0] W4 = {16'h0000, 16'hFF00};
  localparam logic [CW-1:0] W5 = {16'hFF9E, 16'hFF13};
  localparam logic [CW-1:0] W6 = {16'hFF4B, 16'hFF4B};
  localparam logic [CW-1:0] W7 = {16'hFF13, 16'hFF9E};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_CALC = 2'd2
  } fft_state_e;

  function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/fft_sample_buf.sv
// Ping-pong sample storage: one bank is written while the other, complete
// bank is presented as a flat complex operand bus with zero imaginary parts.
module fft_sample_buf
  import fft_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic             wr_bank_i,
  input  logic [LOG2N-1:0] wr_ptr_i,
  input  logic [DW-1:0]    wr_data_i,
  output logic [N*CW-1:0]  rd_data_o
);

  logic [DW-1:0] mem_q [2][N];
  logic [DW-1:0] mem_d [2][N];
  logic          rd_bank;

  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) begin
      mem_d[wr_bank_i][wr_ptr_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N; k++) begin
          mem_q[b][k] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Only the real half is stored; the imaginary half is a constant zero.
  assign rd_bank = ~wr_bank_i;

  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < N; k++) begin
      rd_data_o[CW*k +: CW] = {mem_q[rd_bank][k], {(CW-DW){1'b0}}};
    end
  end

endmodule

// File: rtl/fft_ctrl.sv
// Frame controller for a 16-point FFT: collects samples into ping-pong banks,
// presents each full bank to the butterfly chain and reorders its output.
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int N  = 16,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fir_valid,
  input  logic [DW-1:0]   fir_d,
  output logic [N*CW-1:0] stg_in,
  input  logic [N*CW-1:0] stg_out,
  output logic            fft_valid,
  output logic [N*CW-1:0] fft_d,
  output logic [7:0]      frame_cnt,
  output fft_state_e      dbg_state_o
);

  // Handshake: fir_valid qualifies fir_d for one cycle and is always accepted;
  // fft_valid is a single-cycle pulse with no ready, fft_d holds until the next.

  fft_state_e        state_q, state_d;
  logic [LOG2N-1:0]  wr_ptr_q, wr_ptr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              fft_valid_q, fft_valid_d;
  logic [N*CW-1:0]   fft_d_q, fft_d_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [N*CW-1:0]   spec_nat;
  logic              last_smp;

  fft_sample_buf u_buf (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (fir_valid),
    .wr_bank_i (wr_bank_q),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i (fir_d),
    .rd_data_o (stg_in)
  );

  assign last_smp = fir_valid && (wr_ptr_q == LOG2N'(N-1));

  // The chain delivers bin bitrev(k) in slot k; undo that ordering.
  always_comb begin
    spec_nat = '0;
    for (int k = 0; k < N; k++) begin
      spec_nat[CW*k +: CW] = stg_out[CW*int'(bitrev4(LOG2N'(k))) +: CW];
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_bank_d   = wr_bank_q;
    fft_valid_d = 1'b0;
    fft_d_d     = fft_d_q;
    frame_cnt_d = frame_cnt_q;

    // Sample intake runs in every state, including CALC, so nothing is dropped.
    if (fir_valid) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (last_smp) begin
        wr_bank_d = ~wr_bank_q;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (fir_valid) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (last_smp) begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        state_d     = ST_FILL;
        fft_valid_d = 1'b1;
        fft_d_d     = spec_nat;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      wr_bank_q   <= 1'b0;
      fft_valid_q <= 1'b0;
      fft_d_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_bank_q   <= wr_bank_d;
      fft_valid_q <= fft_valid_d;
      fft_d_q     <= fft_d_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign fft_valid   = fft_valid_q;
  assign fft_d       = fft_d_q;
  assign frame_cnt   = frame_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed and randomized bench for fft_ctrl with a swappable stage-chain
// stand-in (index stub, bit-reversed pass-through, or a direct DFT).
module tb_fft_ctrl;
  import fft_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fir_valid = 1'b0;
  logic [15:0]  fir_d = '0;
  logic [511:0] stg_in;
  logic [511:0] stg_out;
  logic         fft_valid;
  logic [511:0] fft_d;
  logic [7:0]   frame_cnt;
  fft_state_e   dbg_state;

  fft_ctrl #(.N(16), .DW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .fir_valid   (fir_valid),
    .fir_d       (fir_d),
    .stg_in      (stg_in),
    .stg_out     (stg_out),
    .fft_valid   (fft_valid),
    .fft_d       (fft_d),
    .frame_cnt   (frame_cnt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stage-chain stand-in ----------------
  localparam int COS_T[16] = '{256, 237, 181, 98, 0, -98, -181, -237,
                               -256, -237, -181, -98, 0, 98, 181, 237};
  localparam int SIN_T[16] = '{0, 98, 181, 237, 256, 237, 181, 98,
                               0, -98, -181, -237, -256, -237, -181, -98};

  int stub_mode = 0;  // 0 index stub, 1 bit-reversed pass-through, 2 DFT

  function automatic int br(input int k);
    logic [3:0] v;
    logic [3:0] r;
    v = 4'(k);
    r = {v[0], v[1], v[2], v[3]};
    return int'(r);
  endfunction

  function automatic logic [31:0] dft_bin(input logic [511:0] v, input int k);
    int acc_re;
    int acc_im;
    logic signed [15:0] x;
    acc_re = 0;
    acc_im = 0;
    for (int n = 0; n < 16; n++) begin
      x = v[32*n+16 +: 16];
      acc_re += int'(x) * COS_T[(n*k) % 16];
      acc_im -= int'(x) * SIN_T[(n*k) % 16];
    end
    return {16'(acc_re >>> 8), 16'(acc_im >>> 8)};
  endfunction

  always_comb begin
    stg_out = '0;
    for (int m = 0; m < 16; m++) begin
      case (stub_mode)
        0:       stg_out[32*m +: 32] = 32'(m);
        1:       stg_out[32*m +: 32] = stg_in[32*br(m) +: 32];
        default: stg_out[32*m +: 32] = dft_bin(stg_in, br(m));
      endcase
    end
  end

  // ---------------- monitor ----------------
  int           obs_cyc_q[$];
  logic [7:0]   obs_cnt_q[$];
  logic [511:0] obs_d_q[$];

  always @(negedge clk) begin
    if (fft_valid === 1'b1) begin
      obs_cyc_q.push_back(cyc);
      obs_cnt_q.push_back(frame_cnt);
      obs_d_q.push_back(fft_d);
    end
  end

  // ---------------- reference model / scoreboard ----------------
  int           checks = 0;
  int           errors = 0;
  int           frames = 0;
  logic [15:0]  acc_q[$];
  int           exp_cyc_q[$];
  logic [7:0]   exp_cnt_q[$];
  logic [255:0] exp_q[$];
  logic [511:0] exp_spec;
  logic [511:0] last_exp = '0;
  bit           last_tol = 1'b0;

  // Every 16 accepted samples make a frame; its spectrum appears one cycle
  // after the cycle in which the 16th sample was taken.
  function automatic void model_accept(input logic [15:0] s);
    logic [255:0] smp;
    acc_q.push_back(s);
    if (acc_q.size() == 16) begin
      for (int n = 0; n < 16; n++) smp[16*n +: 16] = acc_q[n];
      frames++;
      exp_q.push_back(smp);
      exp_cyc_q.push_back(cyc + 1);
      exp_cnt_q.push_back(8'(frames));
      acc_q.delete();
    end
  endfunction

  function automatic bit near(input logic [15:0] a, input logic [15:0] b);
    int d;
    d = int'($signed(a)) - int'($signed(b));
    return (d >= -1) && (d <= 1);
  endfunction

  function automatic bit spec_match(input logic [511:0] a, input logic [511:0] e, input bit tol);
    for (int k = 0; k < 16; k++) begin
      if (tol) begin
        if (!near(a[32*k+16 +: 16], e[32*k+16 +: 16])) return 1'b0;
        if (!near(a[32*k +: 16], e[32*k +: 16])) return 1'b0;
      end else if (a[32*k +: 32] !== e[32*k +: 32]) begin
        return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frames(input int mode);
    int           ec;
    int           oc;
    logic [7:0]   en;
    logic [7:0]   on;
    logic [255:0] smp;
    logic [511:0] od;
    logic [511:0] ed;
    bit           ok;
    while (exp_cyc_q.size() > 0) begin
      ec  = exp_cyc_q.pop_front();
      en  = exp_cnt_q.pop_front();
      smp = exp_q.pop_front();
      checks++;
      assert (obs_cyc_q.size() > 0) else begin
        errors++;
        $error("FAIL pulse_missing: observed no pulse, expected one at cycle %0d", ec);
      end
      if (obs_cyc_q.size() == 0) continue;
      oc = obs_cyc_q.pop_front();
      on = obs_cnt_q.pop_front();
      od = obs_d_q.pop_front();
      chk32("pulse_cycle", 32'(oc), 32'(ec));
      chk32("frame_cnt", 32'(on), 32'(en));
      ed = '0;
      for (int k = 0; k < 16; k++) begin
        case (mode)
          0:       ed[32*k +: 32] = 32'(br(k));
          1:       ed[32*k +: 32] = {smp[16*k +: 16], 16'h0000};
          default: ed[32*k +: 32] = exp_spec[32*k +: 32];
        endcase
      end
      ok = spec_match(od, ed, mode == 2);
      checks++;
      assert (ok) else begin
        errors++;
        $error("FAIL fft_d: observed %0h expected %0h", od, ed);
      end
      last_exp = ed;
      last_tol = (mode == 2);
    end
    chk32("extra_pulses", 32'(obs_cyc_q.size()), 32'd0);
    obs_cyc_q.delete();
    obs_cnt_q.delete();
    obs_d_q.delete();
  endtask

  task automatic check_hold();
    bit ok;
    ok = spec_match(fft_d, last_exp, last_tol);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL fft_d_hold: observed %0h expected %0h", fft_d, last_exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic [15:0] s);
    fir_valid = 1'b1;
    fir_d     = s;
    @(posedge clk);
    #1;
    fir_valid = 1'b0;
    fir_d     = '0;
    model_accept(s);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A pulse still pending when reset lands is discarded, as is any partial frame.
  task automatic do_reset(input int n, input bit with_valid);
    int r1;
    r1 = cyc + 1;
    rst       = 1'b1;
    fir_valid = with_valid;
    fir_d     = 16'h7FFF;
    repeat (n) @(posedge clk);
    #1;
    rst       = 1'b0;
    fir_valid = 1'b0;
    fir_d     = '0;
    acc_q.delete();
    frames = 0;
    while (exp_cyc_q.size() > 0 && exp_cyc_q[exp_cyc_q.size()-1] >= r1) begin
      void'(exp_cyc_q.pop_back());
      void'(exp_cnt_q.pop_back());
      void'(exp_q.pop_back());
    end
  endtask

  task automatic check_reset_state();
    chk32("rst_fft_valid", 32'(fft_valid), 32'd0);
    chk32("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk32("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    checks++;
    assert (fft_d === '0 && stg_in === '0) else begin
      errors++;
      $error("FAIL rst_data: observed fft_d %0h stg_in %0h expected 0", fft_d, stg_in);
    end
  endtask

  // ---------------- directed steps ----------------
  initial begin
    do_reset(3, 1'b0);
    check_reset_state();

    // Index stub exposes the output reordering.
    stub_mode = 0;
    for (int i = 0; i < 16; i++) push(16'($urandom));
    idle(3);
    check_frames(0);
    idle(5);
    check_hold();

    // Constant input through the DFT: all energy in bin 0.
    do_reset(2, 1'b0);
    stub_mode = 2;
    exp_spec  = '0;
    exp_spec[31:0] = {16'h1000, 16'h0000};
    for (int i = 0; i < 16; i++) push(16'h0100);
    idle(3);
    check_frames(2);

    // Impulse: flat spectrum, first frame after reset.
    do_reset(2, 1'b0);
    for (int k = 0; k < 16; k++) exp_spec[32*k +: 32] = {16'h0100, 16'h0000};
    push(16'h0100);
    for (int i = 1; i < 16; i++) push(16'h0000);
    idle(3);
    check_frames(2);

    // Alternating valid: same DC spectrum, latency measured from the 16th sample.
    exp_spec = '0;
    exp_spec[31:0] = {16'h1000, 16'h0000};
    for (int i = 0; i < 16; i++) begin
      push(16'h0100);
      idle(1);
    end
    idle(3);
    check_frames(2);
    idle(4);
    check_hold();

    // Back-to-back frames: 17th sample lands during CALC.
    stub_mode = 1;
    do_reset(2, 1'b0);
    for (int i = 0; i < 32; i++) push(16'($urandom));
    idle(3);
    check_frames(1);

    // Random gaps between samples.
    for (int i = 0; i < 48; i++) begin
      push(16'($urandom));
      idle($urandom_range(0, 3));
    end
    idle(3);
    check_frames(1);

    // Reset mid-frame with a coincident sample, then a fresh frame.
    for (int i = 0; i < 7; i++) push(16'($urandom));
    do_reset(2, 1'b1);
    check_reset_state();
    for (int i = 0; i < 16; i++) push(16'($urandom));
    idle(3);
    check_frames(1);

    // Reset landing on the CALC cycle cancels that spectrum.
    for (int i = 0; i < 16; i++) push(16'($urandom));
    do_reset(1, 1'b0);
    idle(3);
    check_reset_state();
    check_frames(1);
    for (int i = 0; i < 16; i++) begin
      push(16'($urandom));
      idle($urandom_range(0, 1));
    end
    idle(3);
    check_frames(1);

    // Long run so frame_cnt wraps past 255.
    do_reset(2, 1'b0);
    for (int f = 0; f < 257; f++) begin
      for (int i = 0; i < 16; i++) push(16'($urandom));
    end
    idle(3);
    check_frames(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
